// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, debounces one key, reports each press once.
// Latency: strobe (DEBOUNCE-1)*SCAN_DIV+1 cycles after the detection sample; held drops 1 cycle after the last release sample.
// Backpressure: none; key_strobe is a single-cycle pulse that the consumer must capture when it fires.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_drive,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       key_strobe,
    output logic       key_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    // Count value at which the current matching sample is the DEBOUNCE-th one.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_col_s;
    logic [DW-1:0] r_div;
    state_t        r_state;
    logic [3:0]    r_row_drive;
    logic [3:0]    r_cand_row;
    logic [3:0]    r_cand_col;
    logic [CW-1:0] r_match;
    logic [CW-1:0] r_release;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic          r_strobe;
    logic          r_held;

    state_t        w_state_nxt;
    logic [3:0]    w_row_drive_nxt;
    logic [3:0]    w_cand_row_nxt;
    logic [3:0]    w_cand_col_nxt;
    logic [CW-1:0] w_match_nxt;
    logic [CW-1:0] w_release_nxt;
    logic [3:0]    w_row_nxt;
    logic [3:0]    w_col_nxt;
    logic          w_strobe_nxt;
    logic          w_held_nxt;

    logic          w_sample;
    logic          w_onehot;
    logic [3:0]    w_drive_rot;
    logic [3:0]    w_cand_rot;

    assign w_sample    = (r_div == DIV_LAST);
    assign w_onehot    = (r_col_s != 4'd0) && ((r_col_s & (r_col_s - 4'd1)) == 4'd0);
    assign w_drive_rot = {r_row_drive[2:0], r_row_drive[3]};
    assign w_cand_rot  = {r_cand_row[2:0], r_cand_row[3]};

    assign row_drive  = r_row_drive;
    assign row        = r_row;
    assign col        = r_col;
    assign key_strobe = r_strobe;
    assign key_held   = r_held;

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'd0;
            r_col_s <= 4'd0;
        end else begin
            r_sync1 <= col_in;
            r_col_s <= r_sync1;
        end
    end

    // Free-running dwell counter; its terminal count marks the sample point.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_sample) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_row_drive <= 4'b0001;
            r_cand_row  <= 4'd0;
            r_cand_col  <= 4'd0;
            r_match     <= '0;
            r_release   <= '0;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_strobe    <= 1'b0;
            r_held      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_drive <= w_row_drive_nxt;
            r_cand_row  <= w_cand_row_nxt;
            r_cand_col  <= w_cand_col_nxt;
            r_match     <= w_match_nxt;
            r_release   <= w_release_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_strobe    <= w_strobe_nxt;
            r_held      <= w_held_nxt;
        end
    end

    // Next-state logic: scan, qualify a one-hot column, then track its release.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_drive_nxt = r_row_drive;
        w_cand_row_nxt  = r_cand_row;
        w_cand_col_nxt  = r_cand_col;
        w_match_nxt     = r_match;
        w_release_nxt   = r_release;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_strobe_nxt    = 1'b0;
        w_held_nxt      = r_held;
        case (r_state)
            ST_SCAN: begin
                if (w_sample) begin
                    if (w_onehot) begin
                        w_cand_row_nxt = r_row_drive;
                        w_cand_col_nxt = r_col_s;
                        w_match_nxt    = CW'(1);
                        if (CNT_LAST == CW'(0)) begin
                            // Single-sample debounce: the detection sample already qualifies.
                            w_row_nxt     = r_row_drive;
                            w_col_nxt     = r_col_s;
                            w_strobe_nxt  = 1'b1;
                            w_held_nxt    = 1'b1;
                            w_release_nxt = '0;
                            w_state_nxt   = ST_HELD;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        // Idle, multi-key or ghost pattern: keep scanning.
                        w_row_drive_nxt = w_drive_rot;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_sample) begin
                    if (r_col_s == r_cand_col) begin
                        if (r_match == CNT_LAST) begin
                            w_row_nxt     = r_cand_row;
                            w_col_nxt     = r_cand_col;
                            w_strobe_nxt  = 1'b1;
                            w_held_nxt    = 1'b1;
                            w_release_nxt = '0;
                            w_state_nxt   = ST_HELD;
                        end else begin
                            w_match_nxt = r_match + CW'(1);
                        end
                    end else begin
                        w_match_nxt     = '0;
                        w_row_drive_nxt = w_drive_rot;
                        w_state_nxt     = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                w_row_drive_nxt = r_cand_row;
                if (w_sample) begin
                    if ((r_col_s & r_cand_col) == 4'd0) begin
                        if (r_release == CNT_LAST) begin
                            w_held_nxt      = 1'b0;
                            w_release_nxt   = '0;
                            w_match_nxt     = '0;
                            w_row_drive_nxt = w_cand_rot;
                            w_state_nxt     = ST_SCAN;
                        end else begin
                            w_release_nxt = r_release + CW'(1);
                        end
                    end else begin
                        w_release_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3: directed scenarios plus random key activity.
// A keypad emulator drives col_in from row_drive; a sample-level reference model predicts every output.
// Each scenario task does its own comparisons; one summary line closes the run.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_in;
    logic [3:0] row_drive;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_strobe;
    logic       key_held;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .col_in     (col_in),
        .row_drive  (row_drive),
        .row        (row),
        .col        (col),
        .key_strobe (key_strobe),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Keypad emulation: keys[r*4+c] pressed connects row r to column c.
    logic [15:0] keys = 16'd0;
    bit          use_raw = 1'b0;
    logic [3:0]  raw = 4'd0;

    // Reference model state, expressed as row/column indices and sample counts.
    logic [3:0] m_s1, m_s;
    int         m_div, m_mode, m_ridx, m_cand_idx, m_hits, m_zeros;
    logic [3:0] m_cand_col;
    logic [3:0] e_row, e_col;
    bit         e_strobe, e_held;
    int         m_det_cyc = -1000;
    int         m_rel_cyc = -1000;

    function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] rd);
        logic [3:0] c;
        c = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                if (k[r*4+j] && rd[r]) c[j] = 1'b1;
        return c;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {4'(1 << m_ridx), e_row, e_col, e_strobe, e_held};
    endfunction

    task automatic m_accept();
        e_row    = 4'(1 << m_cand_idx);
        e_col    = m_cand_col;
        e_strobe = 1'b1;
        e_held   = 1'b1;
        m_mode   = 2;
        m_zeros  = 0;
    endtask

    // One clock edge of the reference model; m_s is the synchronized column value seen at this edge.
    task automatic model_step(input logic [3:0] c, input bit rst);
        bit smp;
        if (rst) begin
            m_s1 = 4'd0; m_s = 4'd0; m_div = 0; m_mode = 0; m_ridx = 0;
            m_cand_idx = 0; m_cand_col = 4'd0; m_hits = 0; m_zeros = 0;
            e_row = 4'd0; e_col = 4'd0; e_strobe = 1'b0; e_held = 1'b0;
            return;
        end
        smp = (m_div == SD - 1);
        m_div = (m_div + 1) % SD;
        e_strobe = 1'b0;
        if (smp) begin
            case (m_mode)
                0: begin
                    if ($countones(m_s) == 1) begin
                        m_cand_idx = m_ridx;
                        m_cand_col = m_s;
                        m_hits = 1;
                        m_det_cyc = cyc;
                        if (m_hits >= DB) m_accept();
                        else m_mode = 1;
                    end else begin
                        m_ridx = (m_ridx + 1) % 4;
                    end
                end
                1: begin
                    if (m_s == m_cand_col) begin
                        m_hits++;
                        if (m_hits >= DB) m_accept();
                    end else begin
                        m_mode = 0;
                        m_ridx = (m_ridx + 1) % 4;
                    end
                end
                default: begin
                    if ((m_s & m_cand_col) == 4'd0) begin
                        m_zeros++;
                        if (m_zeros >= DB) begin
                            e_held = 1'b0;
                            m_mode = 0;
                            m_ridx = (m_cand_idx + 1) % 4;
                            m_rel_cyc = cyc;
                        end
                    end else begin
                        m_zeros = 0;
                    end
                end
            endcase
        end
        m_s = m_s1;
        m_s1 = c;
    endtask

    task automatic tick(input bit rst);
        col_in = use_raw ? raw : pad(keys, row_drive);
        reset = rst;
        @(posedge clk);
        model_step(col_in, rst);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        keys = 16'd0; use_raw = 1'b0;
        tick(1'b1); tick(1'b1);
        n_chk++; if (row_drive !== 4'b0001) $display("FAIL rst_row_drive got=%b exp=0001", row_drive); else n_pass++;
        n_chk++; if (row !== 4'b0000) $display("FAIL rst_row got=%b exp=0000", row); else n_pass++;
        n_chk++; if (col !== 4'b0000) $display("FAIL rst_col got=%b exp=0000", col); else n_pass++;
        n_chk++; if (key_strobe !== 1'b0) $display("FAIL rst_strobe got=%b exp=0", key_strobe); else n_pass++;
        n_chk++; if (key_held !== 1'b0) $display("FAIL rst_held got=%b exp=0", key_held); else n_pass++;
    endtask

    task automatic test_press();
        int strobes = 0;
        int s_cyc = -1;
        keys = 16'd0; keys[1*4+2] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL press_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) begin strobes++; s_cyc = cyc; end
        end
        n_chk++; if (strobes != 1) $display("FAIL press_strobe_count got=%0d exp=1", strobes); else n_pass++;
        n_chk++; if (s_cyc - m_det_cyc != 9) $display("FAIL press_latency got=%0d exp=9", s_cyc - m_det_cyc); else n_pass++;
        n_chk++; if (row !== 4'b0010) $display("FAIL press_row got=%b exp=0010", row); else n_pass++;
        n_chk++; if (col !== 4'b0100) $display("FAIL press_col got=%b exp=0100", col); else n_pass++;
        n_chk++; if (key_held !== 1'b1) $display("FAIL press_held got=%b exp=1", key_held); else n_pass++;
    endtask

    task automatic test_hold_release();
        int strobes = 0;
        int f_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL hold_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) strobes++;
        end
        keys = 16'd0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL release_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) strobes++;
            if (key_held === 1'b0 && f_cyc < 0) f_cyc = cyc;
        end
        n_chk++; if (strobes != 0) $display("FAIL hold_extra_strobes got=%0d exp=0", strobes); else n_pass++;
        n_chk++; if (f_cyc - m_rel_cyc != 1) $display("FAIL release_latency got=%0d exp=1", f_cyc - m_rel_cyc); else n_pass++;
        n_chk++; if (row !== 4'b0010) $display("FAIL release_row got=%b exp=0010", row); else n_pass++;
        n_chk++; if (col !== 4'b0100) $display("FAIL release_col got=%b exp=0100", col); else n_pass++;
    endtask

    task automatic test_repress();
        int strobes = 0;
        keys = 16'd0; keys[1*4+2] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL repress_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) strobes++;
        end
        n_chk++; if (strobes != 1) $display("FAIL repress_strobe_count got=%0d exp=1", strobes); else n_pass++;
        keys = 16'd0;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (key_strobe === 1'b1) strobes++;
        end
        n_chk++; if (strobes != 0) $display("FAIL repress_release_strobe got=%0d exp=0", strobes); else n_pass++;
        n_chk++; if (key_held !== 1'b0) $display("FAIL repress_release_held got=%b exp=0", key_held); else n_pass++;
    endtask

    task automatic test_glitch();
        int strobes = 0;
        logic [3:0] first_new = 4'd0;
        bit seen = 1'b0;
        keys = 16'd0; keys[1*4+2] = 1'b1;
        for (int i = 0; i < 80 && m_mode != 1; i++) tick(1'b0);
        keys = 16'd0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL glitch_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) strobes++;
            if (!seen && row_drive !== 4'b0010) begin seen = 1'b1; first_new = row_drive; end
        end
        n_chk++; if (strobes != 0) $display("FAIL glitch_strobe got=%0d exp=0", strobes); else n_pass++;
        n_chk++; if (first_new !== 4'b0100) $display("FAIL glitch_next_row got=%b exp=0100", first_new); else n_pass++;
        n_chk++; if (key_held !== 1'b0) $display("FAIL glitch_held got=%b exp=0", key_held); else n_pass++;
        n_chk++; if ({row, col} !== 8'b0010_0100) $display("FAIL glitch_rowcol got=%b exp=00100100", {row, col}); else n_pass++;
    endtask

    task automatic test_ghost();
        int strobes = 0;
        int rots = 0;
        int bad = 0;
        logic [3:0] prev;
        use_raw = 1'b1; raw = 4'b0101;
        prev = row_drive;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            n_chk++;
            if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                $display("FAIL ghost_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
            else n_pass++;
            if (key_strobe === 1'b1) strobes++;
            if (row_drive !== prev) begin
                if (row_drive === {prev[2:0], prev[3]}) rots++;
                else bad++;
            end
            prev = row_drive;
        end
        use_raw = 1'b0;
        n_chk++; if (strobes != 0) $display("FAIL ghost_strobe got=%0d exp=0", strobes); else n_pass++;
        n_chk++; if (rots != 10 || bad != 0) $display("FAIL ghost_rotation got=%0d/%0d exp=10/0", rots, bad); else n_pass++;
    endtask

    task automatic test_reset_held();
        int strobes = 0;
        keys = 16'd0; keys[2*4+3] = 1'b1;
        for (int i = 0; i < 120 && key_held !== 1'b1; i++) tick(1'b0);
        n_chk++; if (key_held !== 1'b1) $display("FAIL rh_reach_held got=%b exp=1", key_held); else n_pass++;
        tick(1'b1);
        n_chk++; if (row !== 4'b0000) $display("FAIL rh_row got=%b exp=0000", row); else n_pass++;
        n_chk++; if (col !== 4'b0000) $display("FAIL rh_col got=%b exp=0000", col); else n_pass++;
        n_chk++; if (key_held !== 1'b0) $display("FAIL rh_held got=%b exp=0", key_held); else n_pass++;
        n_chk++; if (row_drive !== 4'b0001) $display("FAIL rh_row_drive got=%b exp=0001", row_drive); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            if (key_strobe === 1'b1) strobes++;
        end
        n_chk++; if (strobes != 0) $display("FAIL rh_strobe got=%0d exp=0", strobes); else n_pass++;
        keys = 16'd0;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 40; seg++) begin
            int kind = $urandom_range(0, 4);
            int len = $urandom_range(1, 80);
            bit rst_pulse = ($urandom_range(0, 15) == 0);
            use_raw = 1'b0;
            keys = 16'd0;
            case (kind)
                1, 2: keys[$urandom_range(0, 15)] = 1'b1;
                3: begin
                    keys[$urandom_range(0, 15)] = 1'b1;
                    keys[$urandom_range(0, 15)] = 1'b1;
                end
                4: use_raw = 1'b1;
                default: keys = 16'd0;
            endcase
            for (int i = 0; i < len; i++) begin
                if (kind == 4) raw = 4'($urandom_range(0, 15));
                tick(rst_pulse && i == 0);
                n_chk++;
                if ({row_drive, row, col, key_strobe, key_held} !== exp_vec())
                    $display("FAIL random_track cyc=%0d got=%b exp=%b", cyc, {row_drive, row, col, key_strobe, key_held}, exp_vec());
                else n_pass++;
            end
        end
        use_raw = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        col_in = 4'd0;
        test_reset();
        test_press();
        test_hold_release();
        test_repress();
        test_glitch();
        test_ghost();
        test_reset_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
